// File: rtl/booth_mult_if.sv
// Operand/result bundle for the radix-4 Booth multiplier.
// Ports: A, B, start (to multiplier); ready, out (from multiplier).
interface booth_mult_if;
  logic signed [31:0] A;
  logic signed [31:0] B;
  logic               start;
  logic               ready;
  logic signed [63:0] out;

  modport master (
    output A,
    output B,
    output start,
    input  ready,
    input  out
  );

  modport slave (
    input  A,
    input  B,
    input  start,
    output ready,
    output out
  );
endinterface

// File: rtl/booth_mult.sv
// Signed 32x32->64 sequential multiplier, radix-4 Booth, two digits/clock.
// Ports: clk, rst (sync, active-high), bus (slave: A, B, start, ready, out).
module booth_mult (
  input  logic clk,
  input  logic rst,
  booth_mult_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // acc layout: {hi[33:0], lo[31:0], b_-1}
  state_e       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [33:0]  m_q, m_d;
  logic [66:0]  acc_q, acc_d;
  logic [63:0]  out_q, out_d;

  // One Booth digit: add the selected multiple of M into the upper
  // 34 bits, then arithmetic-shift the whole accumulator right by 2.
  function automatic logic [66:0] booth_step(
    input logic [66:0] a,
    input logic [33:0] m
  );
    logic [33:0] pp;
    logic [33:0] hi;
    unique case (a[2:0])
      3'b001,
      3'b010:  pp = m;
      3'b011:  pp = m << 1;
      3'b100:  pp = -(m << 1);
      3'b101,
      3'b110:  pp = -m;
      default: pp = '0;
    endcase
    hi = a[66:33] + pp;
    return {hi[33], hi[33], hi, a[32:2]};
  endfunction

  logic [66:0] acc_nx;

  always_comb begin
    acc_nx = booth_step(booth_step(acc_q, m_q), m_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    acc_d   = acc_q;
    out_d   = out_q;
    unique case (state_q)
      BUSY: begin
        acc_d = acc_nx;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          out_d   = acc_nx[64:1];
          state_d = DONE;
        end
      end
      default: begin
        if (bus.start) begin
          m_d     = {{2{bus.A[31]}}, bus.A};
          acc_d   = {34'b0, bus.B, 1'b0};
          cnt_d   = 3'd0;
          state_d = BUSY;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign bus.ready = (state_q == DONE);
  assign bus.out   = out_q;

endmodule

// File: tb/tb_booth_mult.sv
// Directed and random checks for booth_mult.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_booth_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  booth_mult_if bus ();

  booth_mult dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle, then count falling edges until ready.
  // lat = number of rising edges after the accepting edge (bounded).
  task automatic launch(input int a, input int b, output int lat);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ready !== 1'b0)
      $display("FAIL reset_ready: got %b expected 0", bus.ready);
    else passed++;
    checks++;
    if (bus.out !== 64'd0)
      $display("FAIL reset_out: got %0d expected 0", bus.out);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    launch(4848, 5151, lat);
    checks++;
    if (lat !== 8)
      $display("FAIL basic_latency: got %0d expected 8", lat);
    else passed++;
    checks++;
    if (bus.out !== 64'sd24972048)
      $display("FAIL basic_out: got %0d expected 24972048", bus.out);
    else passed++;
  endtask

  task automatic test_signs_extremes;
    int          va [8];
    int          vb [8];
    longint      ve [8];
    int          lat;
    va = '{11, -2838594, -2, 100, 0,
           32'h8000_0000, 32'h8000_0000, -1};
    vb = '{7, 74, -7, -89, 23875,
           32'h8000_0000, 32'h7fff_ffff, -1};
    ve = '{64'sd77, -64'sd210055956, 64'sd14, -64'sd8900, 64'sd0,
           64'sd4611686018427387904, -64'sd4611686016279904256, 64'sd1};
    for (int i = 0; i < 8; i++) begin
      launch(va[i], vb[i], lat);
      checks++;
      if (lat !== 8)
        $display("FAIL vec%0d_latency: got %0d expected 8", i, lat);
      else passed++;
      checks++;
      if (bus.out !== ve[i])
        $display("FAIL vec%0d_out: got %0d expected %0d",
                 i, bus.out, ve[i]);
      else passed++;
    end
  endtask

  task automatic test_hold_start;
    int lat;
    @(negedge clk);
    bus.A     = 3;
    bus.B     = 5;
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.A     = 1000;
    bus.B     = -77;
    bus.start = 1'b0;
    lat = 2;
    while (!bus.ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 8)
      $display("FAIL hold_latency: got %0d expected 8", lat);
    else passed++;
    checks++;
    if (bus.out !== 64'sd15)
      $display("FAIL hold_out: got %0d expected 15", bus.out);
    else passed++;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.out !== 64'sd15)
      $display("FAIL hold_done_stable: got ready=%b out=%0d expected 1/15",
               bus.ready, bus.out);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    bus.A     = 123;
    bus.B     = 456;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.ready !== 1'b0 || bus.out !== 64'd0)
      $display("FAIL midreset: got ready=%b out=%0d expected 0/0",
               bus.ready, bus.out);
    else passed++;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.ready !== 1'b0)
      $display("FAIL midreset_idle: got ready=%b expected 0", bus.ready);
    else passed++;
    launch(6, -7, lat);
    checks++;
    if (lat !== 8 || bus.out !== -64'sd42)
      $display("FAIL after_reset: got lat=%0d out=%0d expected 8/-42",
               lat, bus.out);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int lat;
    launch(-5, 9, lat);
    // start presented at the first edge after ready rose
    bus.A     = 7;
    bus.B     = 8;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.ready !== 1'b0)
      $display("FAIL b2b_accept: got ready=%b expected 0", bus.ready);
    else passed++;
    checks++;
    if (bus.out !== -64'sd45)
      $display("FAIL b2b_hold_prev: got %0d expected -45", bus.out);
    else passed++;
    lat = 0;
    while (!bus.ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 8 || bus.out !== 64'sd56)
      $display("FAIL b2b_second: got lat=%0d out=%0d expected 8/56",
               lat, bus.out);
    else passed++;
  endtask

  task automatic test_random;
    int     a;
    int     b;
    int     lat;
    longint e;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom);
      b = int'($urandom);
      e = longint'(a) * longint'(b);
      launch(a, b, lat);
      checks++;
      if (lat !== 8 || bus.out !== e)
        $display("FAIL rand%0d: A=%0d B=%0d got lat=%0d out=%0d expected 8/%0d",
                 i, a, b, lat, bus.out, e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs_extremes();
    test_hold_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
